// File: rtl/unidade_controle.sv
// Multicycle control unit for the 64-bit RISC-V datapath.
// Moore FSM sequencing fetch/decode/execute/memory/write-back; every enable
// and mux select is a decode of the state register and the latched opcode.
//
// state | meaning
// ------+------------------------------------------------------------
// RESET | after reset, all enables low, go to FETCH
// FETCH | weIR=1, opcode latched on exit edge
// DECODE| check latched opcode: supported -> EXEC, else TRAP
// EXEC  | ALU/adders settle; LOAD/STORE -> MEM, BRANCH -> PCUPD, else WB
// MEM   | weMem=1 for STORE; STORE -> PCUPD, LOAD -> WB
// WB    | weReg=1 and wePC=1 together, -> FETCH
// PCUPD | wePC=1, -> FETCH
// TRAP  | illegal=1, enables low, held until reset

module unidade_controle (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  opcode,
   output logic        weIR,
   output logic        wePC,
   output logic        weReg,
   output logic        weMem,
   output logic        sinalMux1,
   output logic [1:0]  sinalMux2,
   output logic        sinalMux4,
   output logic        illegal,
   output logic [2:0]  estado,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_PCUPD  = 3'd6,
      S_TRAP   = 3'd7
   } t_state;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   t_state      r_state;
   logic [6:0]  r_opcode_q;
   logic [31:0] r_instret;

   logic w_supported;
   logic w_is_load;
   logic w_is_store;
   logic w_is_branch;
   logic w_sel_valid;

   assign w_is_load   = (r_opcode_q == OPC_LOAD);
   assign w_is_store  = (r_opcode_q == OPC_STORE);
   assign w_is_branch = (r_opcode_q == OPC_BRANCH);

   // Supported-opcode check on the latched opcode
   always_comb begin
      w_supported = 1'b0;
      case (r_opcode_q)
         OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM,
         OPC_AUIPC, OPC_BRANCH, OPC_JAL, OPC_JALR: w_supported = 1'b1;
         default:                                  w_supported = 1'b0;
      endcase
   end

   // State register, opcode latch and retired-instruction counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_RESET;
         r_opcode_q <= 7'd0;
         r_instret  <= 32'd0;
      end else begin
         if (wePC)
            r_instret <= r_instret + 32'd1;
         case (r_state)
            S_RESET:  r_state <= S_FETCH;
            S_FETCH: begin
               r_opcode_q <= opcode;
               r_state    <= S_DECODE;
            end
            S_DECODE: r_state <= w_supported ? S_EXEC : S_TRAP;
            S_EXEC: begin
               if (w_is_load || w_is_store)
                  r_state <= S_MEM;
               else if (w_is_branch)
                  r_state <= S_PCUPD;
               else
                  r_state <= S_WB;
            end
            S_MEM:    r_state <= w_is_store ? S_PCUPD : S_WB;
            S_WB:     r_state <= S_FETCH;
            S_PCUPD:  r_state <= S_FETCH;
            S_TRAP:   r_state <= S_TRAP;
            default:  r_state <= S_RESET;
         endcase
      end
   end

   // Selects only carry meaning while an instruction is in flight
   assign w_sel_valid = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                        (r_state == S_MEM)    || (r_state == S_WB)   ||
                        (r_state == S_PCUPD);

   // Moore output decode: state register and latched opcode only
   always_comb begin
      weIR      = 1'b0;
      wePC      = 1'b0;
      weReg     = 1'b0;
      weMem     = 1'b0;
      illegal   = 1'b0;
      sinalMux1 = 1'b0;
      sinalMux2 = 2'd0;
      sinalMux4 = 1'b0;
      case (r_state)
         S_FETCH: weIR = 1'b1;
         S_MEM:   weMem = w_is_store;
         S_WB: begin
            weReg = 1'b1;
            wePC  = 1'b1;
         end
         S_PCUPD: wePC = 1'b1;
         S_TRAP:  illegal = 1'b1;
         default: ;
      endcase
      if (w_sel_valid) begin
         sinalMux1 = (r_opcode_q == OPC_OP) || w_is_branch;
         sinalMux4 = (r_opcode_q == OPC_JALR);
         case (r_opcode_q)
            OPC_LOAD:           sinalMux2 = 2'd0;
            OPC_OP, OPC_OPIMM:  sinalMux2 = 2'd1;
            OPC_JAL, OPC_JALR:  sinalMux2 = 2'd2;
            OPC_AUIPC:          sinalMux2 = 2'd3;
            default:            sinalMux2 = 2'd0;
         endcase
      end
   end

   assign estado  = r_state;
   assign instret = r_instret;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: random instruction streams are scored per
// retired instruction against a table-driven model; directed phases cover
// trap, counter wrap and reset aborting a STORE.

module tb_unidade_controle;

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic        weIR, wePC, weReg, weMem, sinalMux1, sinalMux4, illegal;
   logic [1:0]  sinalMux2;
   logic [2:0]  estado;
   logic [31:0] instret;

   unidade_controle dut (
      .clock(clock), .reset(reset), .opcode(opcode),
      .weIR(weIR), .wePC(wePC), .weReg(weReg), .weMem(weMem),
      .sinalMux1(sinalMux1), .sinalMux2(sinalMux2), .sinalMux4(sinalMux4),
      .illegal(illegal), .estado(estado), .instret(instret)
   );

   always #5 clock = ~clock;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   typedef struct {
      int          cycles;
      logic [14:0] sig;
      int          n_reg;
      int          n_mem;
      logic        m1;
      logic [1:0]  m2;
      logic        m4;
      logic [31:0] instret;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_instret;
   logic        mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: state path, enable counts and selects from the
   // instruction-class rules.
   function automatic exp_t model(input logic [6:0] op, input logic [31:0] ir);
      exp_t e;
      int   path[$];
      path = '{1, 2, 3};
      if (op == LOAD || op == STORE) path.push_back(4);
      path.push_back((op == STORE || op == BRANCH) ? 6 : 5);
      e.cycles = path.size();
      e.sig = '0;
      foreach (path[i]) e.sig = {e.sig[11:0], 3'(path[i])};
      e.n_reg = (op == STORE || op == BRANCH) ? 0 : 1;
      e.n_mem = (op == STORE) ? 1 : 0;
      e.m1 = (op == OP || op == BRANCH);
      e.m4 = (op == JALR);
      e.m2 = (op == OP || op == OPIMM) ? 2'd1 :
             (op == JAL || op == JALR) ? 2'd2 :
             (op == AUIPC)             ? 2'd3 : 2'd0;
      e.instret = ir;
      return e;
   endfunction

   // Called at a negedge while the DUT is in FETCH; returns at the next FETCH.
   task automatic run_inst(input logic [6:0] op);
      exp_t e;
      e = model(op, m_instret);
      sb.push_back(e);
      m_instret = m_instret + 32'd1;
      opcode = op;
      repeat (e.cycles - 1) begin
         @(negedge clock);
         opcode = 7'($urandom);
      end
      @(negedge clock);
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 200 && sb.size() > 0; i++) @(negedge clock);
      check("sb_drain_left", sb.size(), 0);
   endtask

   // Monitor: accumulate one instruction from FETCH entry, score it on retire
   int          a_cyc, a_reg, a_mem, a_ir, a_ill;
   logic [14:0] a_sig;
   logic        a_sel_bad;
   logic [3:0]  a_sel;
   logic        pend = 1'b0;
   logic [31:0] pend_val;

   always @(negedge clock) begin
      exp_t e;
      if (pend) begin
         check("instret_inc", instret, pend_val);
         pend = 1'b0;
      end
      if (mon_en) begin
         if (estado == 3'd1) begin
            a_cyc = 0; a_reg = 0; a_mem = 0; a_ir = 0; a_ill = 0;
            a_sig = '0; a_sel_bad = 1'b0; a_sel = '0;
         end
         a_cyc++;
         a_sig = {a_sig[11:0], estado};
         a_reg += int'(weReg);
         a_mem += int'(weMem);
         a_ir  += int'(weIR);
         a_ill += int'(illegal);
         if (estado == 3'd1) begin
            if ({sinalMux1, sinalMux2, sinalMux4} != 4'd0) a_sel_bad = 1'b1;
         end else if (estado == 3'd2) begin
            a_sel = {sinalMux1, sinalMux2, sinalMux4};
         end else if ({sinalMux1, sinalMux2, sinalMux4} != a_sel) begin
            a_sel_bad = 1'b1;
         end
         if (wePC) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_retire", 1, 0);
            end else begin
               e = sb.pop_front();
               check("cycles",    a_cyc, e.cycles);
               check("state_seq", 32'(a_sig), 32'(e.sig));
               check("weReg_cnt", a_reg, e.n_reg);
               check("weMem_cnt", a_mem, e.n_mem);
               check("weIR_cnt",  a_ir, 1);
               check("illegal",   a_ill, 0);
               check("sinalMux1", 32'(a_sel[3]), 32'(e.m1));
               check("sinalMux2", 32'(a_sel[2:1]), 32'(e.m2));
               check("sinalMux4", 32'(a_sel[0]), 32'(e.m4));
               check("sel_stable", 32'(a_sel_bad), 0);
               check("instret_pre", instret, e.instret);
               pend = 1'b1;
               pend_val = e.instret + 32'd1;
            end
         end
      end
   end

   logic [6:0] ops [8];

   initial begin
      ops = '{LOAD, STORE, OP, OPIMM, AUIPC, BRANCH, JAL, JALR};
      reset = 1'b1;
      opcode = 7'd0;
      #3;
      check("rst_estado",  32'(estado), 0);
      check("rst_instret", instret, 0);
      check("rst_enables", 32'({weIR, wePC, weReg, weMem}), 0);
      check("rst_selects", 32'({sinalMux1, sinalMux2, sinalMux4}), 0);
      check("rst_illegal", 32'(illegal), 0);

      // Directed then random instruction stream
      m_instret = 32'd0;
      mon_en = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("post_rst_estado", 32'(estado), 0);
      @(negedge clock);
      check("first_fetch", 32'(estado), 1);
      run_inst(OP);
      check("add_instret", instret, 1);
      run_inst(LOAD);
      run_inst(STORE);
      check("ld_st_instret", instret, 3);
      run_inst(BRANCH);
      run_inst(JAL);
      run_inst(JALR);
      run_inst(AUIPC);
      run_inst(OPIMM);
      for (int i = 0; i < 40; i++) run_inst(ops[$urandom_range(0, 7)]);
      drain();
      mon_en = 1'b0;

      // Unsupported opcode traps and freezes instret
      opcode = 7'b1111111;
      @(negedge clock);
      check("trap_decode", 32'(estado), 2);
      opcode = 7'($urandom);
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         opcode = ops[$urandom_range(0, 7)];
         check("trap_estado",  32'(estado), 7);
         check("trap_illegal", 32'(illegal), 1);
         check("trap_enables", 32'({weIR, wePC, weReg, weMem}), 0);
         check("trap_instret", instret, m_instret);
      end
      #2 reset = 1'b1;
      #1;
      check("trap_rst_estado",  32'(estado), 0);
      check("trap_rst_illegal", 32'(illegal), 0);
      check("trap_rst_instret", instret, 0);

      // instret wraps from all-ones to zero
      @(negedge clock);
      reset = 1'b0;
      force dut.r_instret = 32'hFFFF_FFFF;
      #1 release dut.r_instret;
      m_instret = 32'hFFFF_FFFF;
      mon_en = 1'b1;
      @(negedge clock);
      run_inst(OP);
      drain();
      mon_en = 1'b0;
      check("wrap_instret", instret, 0);

      // Reset during MEM of a STORE drops weMem at once
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      opcode = STORE;
      @(negedge clock);
      opcode = 7'($urandom);
      @(negedge clock);
      @(negedge clock);
      check("st_mem_estado", 32'(estado), 4);
      check("st_mem_weMem",  32'(weMem), 1);
      #2 reset = 1'b1;
      #1;
      check("st_rst_weMem",  32'(weMem), 0);
      check("st_rst_estado", 32'(estado), 0);
      @(negedge clock);
      check("st_rst_hold_enables", 32'({weIR, wePC, weReg, weMem}), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
